tt_sweep_checker: RTL and testbench
===================================

// Module: tt_sweep_checker
// PURPOSE
//  Sequential exhaustive truth-table checker for small combinational gates.
//  Drives every one of the 2^N_IN input vectors onto a DUT in ascending order and
//  waits SETTLE cycles per vector. Samples the DUT output, records it, and compares
//  it against a parameterised expected truth table.
//  Sits between a gate-under-test and the bench (or an on-board LED/switch wrapper).
// PARAMETERS
//  N_IN          3      DUT input count; vectors 0 .. 2^N_IN-1 (1..8 supported)
//  SETTLE        2      cycles each vector is held before sampling (>=1)
//  EXPECT        8'hE8  expected truth table; bit k = DUT output for vector k
//                       (width 2^N_IN)
//  STOP_ON_FAIL  0      1: end the sweep at the first mismatch; 0: sweep all vectors
// PORTS
//  clk         in   1         sole clock, rising edge
//  rst         in   1         asynchronous reset, active-high
//  start       in   1         begin a sweep (sampled in IDLE or DONE only)
//  dut_out     in   1         DUT output for current vec_out
//  vec_out     out  N_IN      registered stimulus vector to DUT (bit N_IN-1 = first DUT input)
//  busy        out  1         sweep in progress (WAIT or SAMPLE)
//  done        out  1         level; sweep finished, results valid
//  pass        out  1         done && err_count==0
//  err_count   out  N_IN+1    number of mismatching vectors
//  fail_valid  out  1         at least one mismatch seen
//  first_fail  out  N_IN      index of the first mismatching vector
//  capture     out  2^N_IN    observed truth table; bit k = sampled dut_out for vector k
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE. All outputs 0: vec_out, busy, done, pass,
//    err_count, fail_valid, first_fail, capture. Reset mid-sweep discards all results.
//  FSM states:
//    IDLE   -> WAIT on start. Clears vec_out, err_count, fail_valid, first_fail,
//              capture and the settle counter.
//    WAIT   -> holds vec_out for SETTLE cycles, then goes to SAMPLE.
//    SAMPLE (1 cycle):
//              capture[vec_out] <= dut_out;
//              on dut_out != EXPECT[vec_out]: err_count++.
//                If !fail_valid: first_fail <= vec_out and fail_valid <= 1.
//              If vec_out == 2^N_IN-1, or (STOP_ON_FAIL && mismatch): -> DONE,
//                and vec_out holds its value.
//              Otherwise vec_out++ and -> WAIT.
//    DONE   -> done=1 and pass valid; results held. start -> WAIT with the same
//              clearing as IDLE, so results are lost.
//  Timing: each vector occupies SETTLE+1 cycles. A full sweep is 2^N_IN*(SETTLE+1)
//    cycles from the first WAIT cycle. done rises the cycle after the last SAMPLE.
//  busy=1 exactly in WAIT/SAMPLE. start while busy is ignored; a held start is
//    not a fault.
//  vec_out never wraps: the sweep ends at the last vector.
//    err_count max is 2^N_IN, which fits in N_IN+1 bits.
//  dut_out is sampled only in SAMPLE. X/Z on dut_out is not detected in RTL;
//    the bench flags it.
// STRUCTURE
//  Shared include tt_defs.vh: state encodings (IDLE/WAIT/SAMPLE/DONE, 2 bits)
//    and a width helper for 2^N_IN.
//  One sub-module: settle_timer (load, count to SETTLE, tick out).
//  The FSM, vector counter and scoreboard registers stay in tt_sweep_checker.
// TESTING
//  1. N_IN=3, SETTLE=2, DUT=majority(a,b,c), start pulse
//     -> vec_out 0..7, each held 3 cycles; done after 24 cycles;
//        capture=8'hE8, err_count=0, pass=1.
//  2. Same, DUT output stuck at 0
//     -> err_count=4, first_fail=3'd3, fail_valid=1, pass=0, capture=8'h00.
//  3. STOP_ON_FAIL=1, stuck-0 DUT
//     -> done after 12 cycles; vec_out=3, err_count=1, capture bits 0..2 = 0.
//  4. rst pulsed while vec_out=4
//     -> same cycle: busy=0, vec_out=0, capture=0. A later start sweeps from
//        vector 0 and test 1 results reproduce.
//  5. start held high through a run, then re-pulsed in DONE
//     -> no restart while busy; the DONE pulse clears err_count/capture and
//        re-sweeps identically.
//  6. N_IN=1, SETTLE=1, EXPECT=2'b10, DUT=buffer
//     -> 2 vectors, done after 4 cycles, pass=1;
//        with an inverter DUT: err_count=2, first_fail=0.

Source files
------------

// File: rtl/tt_sweep_checker_pkg.sv
// Shared FSM state encoding and the truth-table width helper for the sweep checker.
package tt_sweep_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Number of input vectors (and truth-table bits) for an n-input gate.
  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/tt_sweep_checker_settle_timer.sv
// Settle timer: counts enabled cycles and ticks on the SETTLE-th one; load restarts it.
// Latency: tick is combinational on the last settle cycle; no backpressure.
module tt_sweep_checker_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tick
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CW'(SETTLE - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweep: drives vectors 0..2^N_IN-1, samples dut_out after SETTLE cycles.
// Latency: SETTLE+1 cycles per vector; start is ignored while busy.
module tt_sweep_checker
  import tt_sweep_checker_pkg::*;
#(
  parameter int                    N_IN         = 3,
  parameter int                    SETTLE       = 2,
  parameter logic [(1<<N_IN)-1:0]  EXPECT       = 8'hE8,
  parameter bit                    STOP_ON_FAIL = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   dut_out,
  output logic [N_IN-1:0]        vec_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [N_IN:0]          err_count,
  output logic                   fail_valid,
  output logic [N_IN-1:0]        first_fail,
  output logic [(1<<N_IN)-1:0]   capture
);

  localparam int NV = tt_width(N_IN);
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [N_IN:0]     err_q, err_d;
  logic              fv_q, fv_d;
  logic [N_IN-1:0]   ff_q, ff_d;
  logic [NV-1:0]     cap_q, cap_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              mismatch;
  logic              timer_load;
  logic              timer_tick;

  assign mismatch = (dut_out != EXPECT[vec_q]);

  // Restart the settle count on every entry into WAIT.
  assign timer_load = (state_d == ST_WAIT) && (state_q != ST_WAIT);

  tt_sweep_checker_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load),
    .en   (state_q == ST_WAIT),
    .tick (timer_tick)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ff_d    = ff_q;
    cap_d   = cap_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_WAIT;
          vec_d   = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          ff_d    = '0;
          cap_d   = '0;
        end
      end
      ST_WAIT: begin
        if (timer_tick) state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        cap_d[vec_q] = dut_out;
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!fv_q) begin
            fv_d = 1'b1;
            ff_d = vec_q;
          end
        end
        // The last vector never wraps back to 0; vec_out parks on it in DONE.
        if ((vec_q == LAST_VEC) || (STOP_ON_FAIL && mismatch)) begin
          state_d = ST_DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_WAIT) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ff_q    <= '0;
      cap_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ff_q    <= ff_d;
      cap_q   <= cap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign vec_out    = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign first_fail = ff_q;
  assign capture    = cap_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: three configurations driven by table-defined gates, checked against a sweep model.
module tb_tt_sweep_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  int         sel;
  logic [7:0] tbl;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  // Instance A: N_IN=3, SETTLE=2, full sweep
  logic       start_a, dout_a, busy_a, done_a, pass_a, fv_a;
  logic [2:0] vec_a, ff_a;
  logic [3:0] err_a;
  logic [7:0] cap_a;
  // Instance B: same, STOP_ON_FAIL=1
  logic       start_b, dout_b, busy_b, done_b, pass_b, fv_b;
  logic [2:0] vec_b, ff_b;
  logic [3:0] err_b;
  logic [7:0] cap_b;
  // Instance C: N_IN=1, SETTLE=1, EXPECT=2'b10
  logic       start_c, dout_c, busy_c, done_c, pass_c, fv_c;
  logic [0:0] vec_c, ff_c;
  logic [1:0] err_c;
  logic [1:0] cap_c;

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);
  assign dout_a  = tbl[vec_a];
  assign dout_b  = tbl[vec_b];
  assign dout_c  = tbl[vec_c];

  tt_sweep_checker #(.N_IN(3), .SETTLE(2), .EXPECT(8'hE8), .STOP_ON_FAIL(1'b0)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_out(dout_a), .vec_out(vec_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_count(err_a), .fail_valid(fv_a), .first_fail(ff_a),
    .capture(cap_a));

  tt_sweep_checker #(.N_IN(3), .SETTLE(2), .EXPECT(8'hE8), .STOP_ON_FAIL(1'b1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_out(dout_b), .vec_out(vec_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_count(err_b), .fail_valid(fv_b), .first_fail(ff_b),
    .capture(cap_b));

  tt_sweep_checker #(.N_IN(1), .SETTLE(1), .EXPECT(2'b10), .STOP_ON_FAIL(1'b0)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .dut_out(dout_c), .vec_out(vec_c), .busy(busy_c),
    .done(done_c), .pass(pass_c), .err_count(err_c), .fail_valid(fv_c), .first_fail(ff_c),
    .capture(cap_c));

  // Observed outputs of the selected instance, zero-extended to common widths.
  logic       o_busy, o_done, o_pass, o_fv;
  logic [7:0] o_vec, o_ff, o_cap, o_err;

  always_comb begin
    o_busy = busy_a; o_done = done_a; o_pass = pass_a; o_fv = fv_a;
    o_vec = {5'b0, vec_a}; o_ff = {5'b0, ff_a}; o_cap = cap_a; o_err = {4'b0, err_a};
    if (sel == 1) begin
      o_busy = busy_b; o_done = done_b; o_pass = pass_b; o_fv = fv_b;
      o_vec = {5'b0, vec_b}; o_ff = {5'b0, ff_b}; o_cap = cap_b; o_err = {4'b0, err_b};
    end else if (sel == 2) begin
      o_busy = busy_c; o_done = done_c; o_pass = pass_c; o_fv = fv_c;
      o_vec = {7'b0, vec_c}; o_ff = {7'b0, ff_c}; o_cap = {6'b0, cap_c}; o_err = {6'b0, err_c};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One sweep on instance s with the gate defined by truth table t, checked against the model.
  task automatic run_sweep(input int s, input logic [7:0] t, input bit hold, input string nm);
    int         nin, settle, nv, errs, ff, last, cycles, n, bad;
    bit         stopf, fv, stopped;
    logic [7:0] e, cap;

    case (s)
      0:       begin nin = 3; settle = 2; e = 8'hE8; stopf = 1'b0; end
      1:       begin nin = 3; settle = 2; e = 8'hE8; stopf = 1'b1; end
      default: begin nin = 1; settle = 1; e = 8'h02; stopf = 1'b0; end
    endcase

    nv = 1 << nin; errs = 0; ff = 0; fv = 1'b0; cap = 8'h00; last = nv - 1; stopped = 1'b0;
    for (int k = 0; k < nv; k++) begin
      if (!stopped) begin
        cap[k] = t[k];
        if (t[k] != e[k]) begin
          errs++;
          if (!fv) begin fv = 1'b1; ff = k; end
          if (stopf) begin last = k; stopped = 1'b1; end
        end
      end
    end
    cycles = (last + 1) * (settle + 1);

    sel = s;
    tbl = t;
    @(negedge clk); start = 1'b1;
    @(negedge clk); if (!hold) start = 1'b0;
    n = 0; bad = 0;
    while (!o_done && n < 1000) begin
      if (o_vec !== 8'(n / (settle + 1)) || o_busy !== 1'b1) bad++;
      @(negedge clk);
      n++;
      if (hold && n == 10) start = 1'b0;
    end
    start = 1'b0;

    chk({nm, ".cycles"}, 64'(n), 64'(cycles));
    chk({nm, ".vec_seq"}, 64'(bad), 64'd0);
    chk({nm, ".capture"}, o_cap, cap);
    chk({nm, ".err_count"}, o_err, 8'(errs));
    chk({nm, ".fail_valid"}, o_fv, fv);
    if (fv) chk({nm, ".first_fail"}, o_ff, 8'(ff));
    chk({nm, ".pass"}, o_pass, (errs == 0));
    chk({nm, ".busy_end"}, o_busy, 1'b0);
    repeat (3) @(negedge clk);
    chk({nm, ".held"}, {o_done, o_vec}, {1'b1, 8'(last)});
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; sel = 0; tbl = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset.a", {vec_a, busy_a, done_a, pass_a, err_a, fv_a, ff_a, cap_a}, 64'd0);
    chk("reset.c", {vec_c, busy_c, done_c, pass_c, err_c, fv_c, ff_c, cap_c}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_sweep(0, 8'hE8, 1'b0, "majority");
    run_sweep(0, 8'h00, 1'b0, "stuck0");
    run_sweep(0, 8'hE8, 1'b1, "held_start");
    run_sweep(0, 8'h00, 1'b0, "repulse");
    run_sweep(1, 8'hE8, 1'b0, "stop_majority");
    run_sweep(1, 8'h00, 1'b0, "stop_stuck0");

    // Asynchronous reset in the middle of a sweep
    sel = 0; tbl = 8'hE8;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (o_vec !== 8'd4 && n < 100) begin @(negedge clk); n++; end
    chk("rst_mid.reach_vec4", o_vec, 8'd4);
    rst = 1'b1;
    #1;
    chk("rst_mid.busy", o_busy, 1'b0);
    chk("rst_mid.vec", o_vec, 8'd0);
    chk("rst_mid.capture", o_cap, 8'd0);
    chk("rst_mid.err_done", {o_err, o_done, o_fv}, 10'd0);
    @(negedge clk); rst = 1'b0;
    run_sweep(0, 8'hE8, 1'b0, "post_reset");

    run_sweep(2, 8'h02, 1'b0, "n1_buffer");
    run_sweep(2, 8'h01, 1'b0, "n1_inverter");

    for (int i = 0; i < 4; i++) begin
      run_sweep(0, 8'($urandom_range(255)), 1'b0, "rand_full");
      run_sweep(1, 8'($urandom_range(255)), 1'b0, "rand_stop");
      run_sweep(2, 8'($urandom_range(3)), 1'b0, "rand_n1");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
